// File: rtl/udp_rx_parse.sv
// udp_rx_parse: receive-side Ethernet II / IPv4 (IHL=5) / UDP header parser.
// Works on the 16-bit window of the upstream byte shift stage. It checks the
// header, captures the source IP and UDP length, and forwards only the UDP
// payload bytes, so Ethernet padding never reaches the consumer.
// Optional build macro: RX_IP_FILTER_EN. When it is defined, frames whose IPv4
// destination differs from LOCAL_IP are dropped. When it is undefined, any
// destination address is accepted.
module udp_rx_parse #(
   parameter logic [15:0] LOCAL_PORT = 16'h1F90,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic        rx_sof,
   input  logic        rx_eof,
   input  logic [15:0] win16,
   output logic [31:0] src_ip,
   output logic [15:0] udp_len,
   output logic        hdr_ok,
   output logic        pl_valid,
   output logic [7:0]  pl_data,
   output logic        pl_last,
   output logic        frame_drop
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_DONE    = 3'd3,
      S_DROP    = 3'd4
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic        vld_d1;
   logic        sof_d1;
   logic        eof_d1;
   logic [5:0]  idx_reg;
   logic [5:0]  cur_idx;
   logic [15:0] pl_cnt_reg;
   logic [15:0] pl_load;
   logic        hdr_fail;
   logic        hdr_ok_next;
   logic        pl_valid_next;
   logic        pl_last_next;
   logic        drop_next;

`ifdef RX_IP_FILTER_EN
   logic [15:0] dst_hi_reg;
`else
   logic        unused_ip_cfg;
   assign unused_ip_cfg = ^LOCAL_IP;
`endif

   // Index of the byte now sitting in win16[7:0]; a start-of-frame byte is always index 0
   assign cur_idx = sof_d1 ? 6'd0 : idx_reg;
   assign pl_load = udp_len - 16'd8;

   // Delay the strobe and framing flags by one clock so they line up with win16
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_d1 <= 1'b0;
         sof_d1 <= 1'b0;
         eof_d1 <= 1'b0;
      end else begin
         vld_d1 <= rx_valid;
         sof_d1 <= rx_valid & rx_sof;
         eof_d1 <= rx_valid & rx_eof;
      end
   end

   // Header field checks for the byte at cur_idx; only consulted while in HDR
   always_comb begin
      hdr_fail = 1'b0;
      case (cur_idx)
         6'd13:   hdr_fail = (win16 != 16'h0800);
         6'd14:   hdr_fail = (win16[7:0] != 8'h45);
         6'd23:   hdr_fail = (win16[7:0] != 8'h11);
`ifdef RX_IP_FILTER_EN
         6'd33:   hdr_fail = ({dst_hi_reg, win16} != LOCAL_IP);
`endif
         6'd37:   hdr_fail = (win16 != LOCAL_PORT);
         6'd39:   hdr_fail = (win16 < 16'd8);
         default: hdr_fail = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic; a start-of-frame byte restarts parsing from any state
   always_comb begin
      state_next = state_reg;
      if (vld_d1) begin
         if (sof_d1) begin
            state_next = eof_d1 ? S_IDLE : S_HDR;
         end else begin
            case (state_reg)
               S_HDR: begin
                  if (eof_d1)                state_next = S_IDLE;
                  else if (hdr_fail)         state_next = S_DROP;
                  else if (cur_idx == 6'd41) state_next = (pl_load == 16'd0) ? S_DONE : S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  if (eof_d1)                    state_next = S_IDLE;
                  else if (pl_cnt_reg == 16'd1)  state_next = S_DONE;
               end
               S_DONE, S_DROP: begin
                  if (eof_d1) state_next = S_IDLE;
               end
               default: state_next = state_reg;
            endcase
         end
      end
   end

   // Output decode; results are registered so they land two clocks after rx_valid
   always_comb begin
      hdr_ok_next   = 1'b0;
      pl_valid_next = 1'b0;
      pl_last_next  = 1'b0;
      drop_next     = 1'b0;
      if (vld_d1) begin
         if (sof_d1) begin
            drop_next = eof_d1 || (state_reg == S_HDR) || (state_reg == S_PAYLOAD);
         end else begin
            case (state_reg)
               S_HDR: begin
                  if (cur_idx == 6'd41) begin
                     hdr_ok_next = 1'b1;
                     // Frame ended right after the header while payload was still owed
                     drop_next   = eof_d1 && (pl_load != 16'd0);
                  end else begin
                     drop_next   = eof_d1 || hdr_fail;
                  end
               end
               S_PAYLOAD: begin
                  pl_valid_next = 1'b1;
                  pl_last_next  = eof_d1 || (pl_cnt_reg == 16'd1);
                  drop_next     = eof_d1 && (pl_cnt_reg != 16'd1);
               end
               default: begin
                  drop_next = 1'b0;
               end
            endcase
         end
      end
   end

   // Byte index, header field captures and payload countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg    <= 6'd0;
         pl_cnt_reg <= 16'd0;
         src_ip     <= 32'd0;
         udp_len    <= 16'd0;
`ifdef RX_IP_FILTER_EN
         dst_hi_reg <= 16'd0;
`endif
      end else if (vld_d1) begin
         if (cur_idx != 6'h3F) idx_reg <= cur_idx + 6'd1;
         if (state_reg == S_HDR) begin
            if (cur_idx == 6'd27) src_ip[31:16] <= win16;
            if (cur_idx == 6'd29) src_ip[15:0]  <= win16;
`ifdef RX_IP_FILTER_EN
            if (cur_idx == 6'd31) dst_hi_reg    <= win16;
`endif
            if (cur_idx == 6'd39) udp_len       <= win16;
            if (cur_idx == 6'd41) pl_cnt_reg    <= pl_load;
         end else if (state_reg == S_PAYLOAD && !sof_d1) begin
            pl_cnt_reg <= pl_cnt_reg - 16'd1;
         end
      end
   end

   // Registered outputs; pl_data holds the last forwarded byte between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_ok     <= 1'b0;
         pl_valid   <= 1'b0;
         pl_last    <= 1'b0;
         frame_drop <= 1'b0;
         pl_data    <= 8'd0;
      end else begin
         hdr_ok     <= hdr_ok_next;
         pl_valid   <= pl_valid_next;
         pl_last    <= pl_last_next;
         frame_drop <= drop_next;
         if (pl_valid_next) pl_data <= win16[7:0];
      end
   end

endmodule

// File: tb/tb_udp_rx_parse.sv
// Testbench for udp_rx_parse. It models the upstream byte shift stage, builds
// frames byte by byte, and scoreboards payload, header-accept and drop events
// against their exact expected cycle.
module tb_udp_rx_parse;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic [7:0]  rx_data;
   logic [15:0] win16 = 16'd0;
   logic [31:0] src_ip;
   logic [15:0] udp_len;
   logic        hdr_ok;
   logic        pl_valid;
   logic [7:0]  pl_data;
   logic        pl_last;
   logic        frame_drop;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct { int cyc; logic [7:0] data; logic last; } pl_exp_t;
   typedef struct { int cyc; logic [31:0] sip; logic [15:0] ulen; } hdr_exp_t;

   pl_exp_t     pl_q[$];
   hdr_exp_t    hdr_q[$];
   int          drop_q[$];
   logic [7:0]  fr [0:127];

   udp_rx_parse dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_sof     (rx_sof),
      .rx_eof     (rx_eof),
      .win16      (win16),
      .src_ip     (src_ip),
      .udp_len    (udp_len),
      .hdr_ok     (hdr_ok),
      .pl_valid   (pl_valid),
      .pl_data    (pl_data),
      .pl_last    (pl_last),
      .frame_drop (frame_drop)
   );

   always #5 clk = ~clk;

   // Cycle counter and model of the upstream shift stage
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_valid) win16 <= {win16[7:0], rx_data};
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach the summary, required completion");
      $fatal(1, "timeout");
   end

   // One clock: scoreboard the outputs at the falling edge, then return just after the rising edge
   task automatic tick();
      pl_exp_t  pe;
      hdr_exp_t he;
      @(negedge clk);
      if (pl_q.size() > 0 && pl_q[0].cyc == cyc) begin
         pe = pl_q.pop_front();
         checks++;
         if (pl_valid !== 1'b1 || pl_data !== pe.data || pl_last !== pe.last) begin
            errors++;
            $display("FAIL payload @%0d: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     cyc, pl_valid, pl_data, pl_last, pe.data, pe.last);
         end
      end else if (pl_valid !== 1'b0) begin
         checks++; errors++;
         $display("FAIL payload_unexpected @%0d: got valid=%b data=%h, expected valid=0", cyc, pl_valid, pl_data);
      end
      if (hdr_q.size() > 0 && hdr_q[0].cyc == cyc) begin
         he = hdr_q.pop_front();
         checks++;
         if (hdr_ok !== 1'b1 || src_ip !== he.sip || udp_len !== he.ulen) begin
            errors++;
            $display("FAIL hdr_ok @%0d: got hdr_ok=%b src_ip=%h udp_len=%h, expected 1 %h %h",
                     cyc, hdr_ok, src_ip, udp_len, he.sip, he.ulen);
         end
      end else if (hdr_ok !== 1'b0) begin
         checks++; errors++;
         $display("FAIL hdr_ok_unexpected @%0d: got %b, expected 0", cyc, hdr_ok);
      end
      if (drop_q.size() > 0 && drop_q[0] == cyc) begin
         void'(drop_q.pop_front());
         checks++;
         if (frame_drop !== 1'b1) begin
            errors++;
            $display("FAIL frame_drop @%0d: got %b, expected 1", cyc, frame_drop);
         end
      end else if (frame_drop !== 1'b0) begin
         checks++; errors++;
         $display("FAIL frame_drop_unexpected @%0d: got %b, expected 0", cyc, frame_drop);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] b, input bit sof, input bit eof);
      tick();
      rx_valid = 1'b1;
      rx_data  = b;
      rx_sof   = sof;
      rx_eof   = eof;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         rx_valid = 1'b0;
         rx_sof   = 1'b0;
         rx_eof   = 1'b0;
         rx_data  = 8'h00;
      end
   endtask

   // Frame image: Ethernet II + IPv4 + UDP header, payload AA BB CC DD 54 55 ..., zero padding
   task automatic build_frame(input logic [15:0] etype, input logic [7:0] ver, input logic [7:0] proto,
                              input logic [31:0] sip, input logic [31:0] dip,
                              input logic [15:0] dport, input logic [15:0] ulen);
      int npl;
      npl = int'(ulen) - 8;
      for (int i = 0; i < 128; i++) fr[i] = 8'h00;
      for (int i = 0; i < 12; i++) fr[i] = 8'h10 + 8'(i);
      {fr[12], fr[13]} = etype;
      fr[14] = ver;
      {fr[16], fr[17]} = 16'd20 + ulen;
      fr[22] = 8'h40;
      fr[23] = proto;
      {fr[26], fr[27], fr[28], fr[29]} = sip;
      {fr[30], fr[31], fr[32], fr[33]} = dip;
      {fr[34], fr[35]} = 16'hC000;
      {fr[36], fr[37]} = dport;
      {fr[38], fr[39]} = ulen;
      for (int k = 0; k < npl && 42 + k < 128; k++) begin
         case (k)
            0:       fr[42 + k] = 8'hAA;
            1:       fr[42 + k] = 8'hBB;
            2:       fr[42 + k] = 8'hCC;
            3:       fr[42 + k] = 8'hDD;
            default: fr[42 + k] = 8'h50 + 8'(k);
         endcase
      end
   endtask

   // Send bytes 0..n_send-1 and push the expected events (each 2 cycles after its byte)
   task automatic send_frame(input int n_send, input bit with_eof, input bit gapped,
                             input int hdr_at, input int drop_at,
                             input int pl_lo, input int pl_hi, input int last_at,
                             input logic [31:0] esip, input logic [15:0] eulen);
      for (int i = 0; i < n_send; i++) begin
         if (gapped && i != 0) idle(1);
         drive_byte(fr[i], i == 0, with_eof && (i == n_send - 1));
         if (i == hdr_at) hdr_q.push_back('{cyc: cyc + 2, sip: esip, ulen: eulen});
         if (i == drop_at) drop_q.push_back(cyc + 2);
         if (i >= pl_lo && i < pl_hi) pl_q.push_back('{cyc: cyc + 2, data: fr[i], last: (i == last_at)});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
      #2;
      checks++;
      if ({src_ip, udp_len, hdr_ok, pl_valid, pl_data, pl_last, frame_drop} !== 63'd0) begin
         errors++;
         $display("FAIL reset_outputs: got src_ip=%h udp_len=%h hdr_ok=%b pl_valid=%b pl_data=%h pl_last=%b drop=%b, expected all 0",
                  src_ip, udp_len, hdr_ok, pl_valid, pl_data, pl_last, frame_drop);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_valid_frame();
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, 41, -1, 42, 46, 45, 32'hC0A8_010A, 16'h000C);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL valid_frame_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
      checks++;
      if (src_ip !== 32'hC0A8_010A || udp_len !== 16'h000C) begin
         errors++;
         $display("FAIL valid_frame_hold: got src_ip=%h udp_len=%h, expected C0A8010A 000C", src_ip, udp_len);
      end
   endtask

   task automatic test_arp();
      build_frame(16'h0806, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, -1, 13, 0, 0, -1, 32'h0, 16'h0);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL arp_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F91, 16'd12);
      send_frame(60, 1, 0, -1, 37, 0, 0, -1, 32'h0, 16'h0);
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010B, 32'hC0A8_0102, 16'h1F90, 16'd14);
      send_frame(60, 1, 0, 41, -1, 42, 48, 47, 32'hC0A8_010B, 16'h000E);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL back_to_back_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   task automatic test_bad_fields();
      build_frame(16'h0800, 8'h46, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, -1, 14, 0, 0, -1, 32'h0, 16'h0);
      build_frame(16'h0800, 8'h45, 8'h06, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, -1, 23, 0, 0, -1, 32'h0, 16'h0);
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd7);
      send_frame(60, 1, 0, -1, 39, 0, 0, -1, 32'h0, 16'h0);
      // Empty UDP payload: header accepted, nothing forwarded
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_0133, 32'hC0A8_0102, 16'h1F90, 16'd8);
      send_frame(60, 1, 0, 41, -1, 0, 0, -1, 32'hC0A8_0133, 16'h0008);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL bad_fields_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   task automatic test_early_eof_and_runt();
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(21, 1, 0, -1, 20, 0, 0, -1, 32'h0, 16'h0);
      idle(2);
      send_frame(1, 1, 0, -1, 0, 0, 0, -1, 32'h0, 16'h0);
      // Payload length 12 but the frame ends after 4 payload bytes
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_0144, 32'hC0A8_0102, 16'h1F90, 16'd20);
      send_frame(46, 1, 0, 41, 45, 42, 46, 45, 32'hC0A8_0144, 16'h0014);
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, 41, -1, 42, 46, 45, 32'hC0A8_010A, 16'h000C);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL eof_runt_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   task automatic test_sof_restart();
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(44, 0, 0, 41, -1, 42, 44, -1, 32'hC0A8_010A, 16'h000C);
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_0114, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, 41, 0, 42, 46, 45, 32'hC0A8_0114, 16'h000C);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL sof_restart_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   task automatic test_ip_filter();
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_0155, 32'hC0A8_0103, 16'h1F90, 16'd12);
`ifdef RX_IP_FILTER_EN
      send_frame(60, 1, 0, -1, 33, 0, 0, -1, 32'h0, 16'h0);
`else
      send_frame(60, 1, 0, 41, -1, 42, 46, 45, 32'hC0A8_0155, 16'h000C);
`endif
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL ip_filter_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   task automatic test_gapped_and_reset();
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 1, 41, -1, 42, 46, 45, 32'hC0A8_010A, 16'h000C);
      idle(4);
      // Reset after the third payload byte has been forwarded
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_0166, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(45, 0, 1, 41, -1, 42, 45, -1, 32'hC0A8_0166, 16'h000C);
      idle(3);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({src_ip, udp_len, hdr_ok, pl_valid, pl_data, pl_last, frame_drop} !== 63'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got src_ip=%h udp_len=%h hdr_ok=%b pl_valid=%b pl_data=%h pl_last=%b drop=%b, expected all 0",
                  src_ip, udp_len, hdr_ok, pl_valid, pl_data, pl_last, frame_drop);
      end
      idle(2);
      rst_n = 1'b1;
      // Tail of the interrupted frame carries no rx_sof, so nothing may come out
      for (int i = 45; i < 60; i++) drive_byte(fr[i], 1'b0, i == 59);
      idle(4);
      build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A8_010A, 32'hC0A8_0102, 16'h1F90, 16'd12);
      send_frame(60, 1, 0, 41, -1, 42, 46, 45, 32'hC0A8_010A, 16'h000C);
      idle(4);
      checks++;
      if (pl_q.size() != 0 || hdr_q.size() != 0 || drop_q.size() != 0) begin
         errors++;
         $display("FAIL gapped_reset_drain: pending pl=%0d hdr=%0d drop=%0d, required 0", pl_q.size(), hdr_q.size(), drop_q.size());
         pl_q.delete(); hdr_q.delete(); drop_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_arp();
      test_back_to_back();
      test_bad_fields();
      test_early_eof_and_runt();
      test_sof_restart();
      test_ip_filter();
      test_gapped_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_rx_parse.md
# udp_rx_parse

Receive-side header parser for the TOE datapath. It sits directly downstream of the 32-bit byte shift register and consumes that stage's 16-bit window, `win16`, alongside the same byte strobe. It recognises Ethernet II / IPv4 (IHL=5) / UDP frames addressed to the local port and extracts the source IP and UDP length. It forwards only the UDP payload bytes, with Ethernet padding stripped, to the camera command logic.

## Interface
- `LOCAL_PORT`, default 16'h1F90: accepted UDP destination port.
- `LOCAL_IP`, default 32'hC0A8_0102: accepted IPv4 destination, used only with `RX_IP_FILTER_EN`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  byte strobe; the same signal that drives the shift stage's `data_valid`.
- `rx_sof`  in  1  first byte of frame (destination MAC byte 0); qualified by `rx_valid`.
- `rx_eof`  in  1  last byte of frame; qualified by `rx_valid`.
- `win16`  in  16  shift-stage output; `[7:0]` holds the byte strobed in the previous cycle, `[15:8]` the one before.
- `src_ip`  out  32  IPv4 source address of the accepted frame.
- `udp_len`  out  16  UDP length field of the accepted frame.
- `hdr_ok`  out  1  1-cycle pulse when the header is fully accepted.
- `pl_valid`  out  1  payload byte strobe.
- `pl_data`  out  8  payload byte.
- `pl_last`  out  1  with `pl_valid`, marks the final payload byte.
- `frame_drop`  out  1  1-cycle pulse when a frame is rejected or aborted.

## Operation
- Internal `vld_d1`, `sof_d1` and `eof_d1` are `rx_*` delayed by one clock, so they align with `win16`. All parsing acts on `vld_d1` cycles only.
- `idx` (6-bit) counts header bytes. It is 0 on the `sof_d1` byte and increments on each `vld_d1`. Checks run on `win16` at these index values:
  - `idx`=13: `win16` must equal 16'h0800.
  - `idx`=14: `win16[7:0]` must equal 8'h45.
  - `idx`=23: `win16[7:0]` must equal 8'h11.
  - `idx`=27 and 29: capture `src_ip[31:16]` and `src_ip[15:0]` from `win16`.
  - `idx`=31 and 33: capture the destination IP.
  - `idx`=33: compare against `LOCAL_IP` (macro-gated).
  - `idx`=37: `win16` must equal `LOCAL_PORT`.
  - `idx`=39: capture `udp_len`; must satisfy `udp_len` ≥ 8.
  - `idx`=41: pulse `hdr_ok`, load `pl_cnt = udp_len - 8`, then go to PAYLOAD, or to DONE if `pl_cnt` is 0.
- FSM states:
  - IDLE: `sof_d1` goes to HDR.
  - HDR: any failed check goes to DROP and pulses `frame_drop`. `eof_d1` before `idx`=41 goes to IDLE and pulses `frame_drop`.
  - PAYLOAD: each `vld_d1` emits `pl_data = win16[7:0]` and decrements `pl_cnt`. When `pl_cnt` reaches 1, also assert `pl_last` and go to DONE. `eof_d1` while `pl_cnt` > 1 ends the frame as truncated: emit that byte with `pl_last`, pulse `frame_drop`, go to IDLE.
  - DONE: ignore padding bytes; `eof_d1` goes to IDLE.
  - DROP: ignore bytes; `eof_d1` goes to IDLE.
- `sof_d1` in any state other than IDLE restarts parsing at `idx`=0 in HDR. A `frame_drop` pulse is issued if the state was HDR or PAYLOAD.
- A byte carrying both `sof_d1` and `eof_d1` is a runt: pulse `frame_drop` and stay in IDLE.
- `src_ip` and `udp_len` hold their values until the next capture.

## Timing
- Reset: state IDLE; `idx`, `pl_cnt`, `src_ip` and `udp_len` are 0; `hdr_ok`, `pl_valid`, `pl_last` and `frame_drop` are 0; `pl_data` is 0.
- Latency: `rx_valid` high in cycle n means `pl_valid` and `pl_data` are high/valid in cycle n+2. `hdr_ok` and `frame_drop` also appear 2 cycles after the deciding `rx_valid`.
- Back-to-back `rx_valid` is supported, one byte per clock; gaps in `rx_valid` are allowed anywhere.
- No backpressure: the consumer must accept `pl_valid` every cycle.
- Reset mid-frame returns to IDLE immediately; the next frame must begin with `rx_sof`.

## Configuration
- `RX_IP_FILTER_EN` defined: at `idx`=33 a destination IP not equal to `LOCAL_IP` goes to DROP with a `frame_drop` pulse.
- `RX_IP_FILTER_EN` undefined: the destination IP is not compared; any IPv4 destination is accepted.

## Test plan
- Valid 60-byte frame: EtherType 0800, 45, proto 11, src 192.168.1.10, port 1F90, `udp_len`=12, then bytes AA BB CC DD followed by padding. Required: `hdr_ok` once, `src_ip`=C0A8_010A, `udp_len`=000C, `pl_data` AA..DD with `pl_last` on DD, no padding forwarded, `pl_valid` 2 cycles after each byte.
- EtherType 0806 (ARP): `frame_drop` 2 cycles after byte 13; no `hdr_ok`, no `pl_valid`.
- Port 1F91: `frame_drop` after byte 37; then an immediate valid frame parses correctly.
- `rx_eof` at byte 20: `frame_drop` pulse; state returns to IDLE.
- `rx_sof` arriving at payload byte 2 of the previous frame: `frame_drop`, new frame accepted. With `RX_IP_FILTER_EN`, destination C0A8_0103 is dropped; without it, the same frame is accepted.
- `rx_valid` gapped every other cycle, plus `rst_n` asserted mid-payload: output bytes are identical to the gap-free case, and all outputs clear on reset.
